// File: rtl/mio_arbiter.sv
// mio_arbiter -- two-master arbiter for the shared memory/IO bus.
//
// Master 0 is the CPU memory port and master 1 is a DMA/VGA-style requester.
// One access at a time is placed on the single memory slave. The slave's
// acknowledge comes back to the winning master as a one-cycle ready pulse,
// and that master's read data is registered alongside it. The FSM state is
// exported for debug. Every output is a flop.
//
// Optional feature: define ARB_TIMEOUT_EN to add an access watchdog. It
// aborts an access after TIMEOUT cycles without mem_ack, returns
// 32'hDEADBEEF to a reader and pulses bus_err with ready. Without the macro,
// an access waits for mem_ack forever and bus_err stays 0.
//
// Parameters:
//   ADDR_W   address width of all ports
//   DATA_W   data width of all ports
//   PRIO_CPU 0 = round-robin on a tie, 1 = CPU always wins a tie
//   TIMEOUT  watchdog limit in cycles (ARB_TIMEOUT_EN only, 1..65535)
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata  CPU request; req is held until cpu_ready
//   cpu_rdata, cpu_ready   CPU read data and one-cycle completion pulse
//   dma_*                  same set of ports for master 1
//   mem_cs/we/addr/wdata   slave request; held stable for the whole access
//   mem_rdata, mem_ack     slave read data and completion
//   bus_err                watchdog abort, pulses together with ready
//   grant                  one-hot owner: bit0 = CPU, bit1 = DMA
//   state_out              FSM state: 0 IDLE, 1 CPU_ACC, 2 DMA_ACC, 3 RESP
module mio_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter bit PRIO_CPU = 1'b0,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ready,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err,
    output logic [1:0]        grant,
    output logic [1:0]        state_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DMA_ACC = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t state;
    logic   last_grant;   // 0 = CPU owned the bus last, 1 = DMA did
    logic   pick_dma;

    // The watchdog counter is 16 bits wide, so any larger limit is unreachable.
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("mio_arbiter: TIMEOUT must be in 1..65535");
    end

`ifdef ARB_TIMEOUT_EN
    // The counter advances on every ACC cycle without mem_ack, so matching
    // TIMEOUT-1 aborts on the edge that ends the TIMEOUT-th waiting cycle.
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
    logic [15:0] wd_cnt;
`endif

    // On a tie, round-robin picks whichever master did not own the bus last.
    always_comb begin
        pick_dma = dma_req;
        if (cpu_req && dma_req) begin
            pick_dma = PRIO_CPU ? 1'b0 : ~last_grant;
        end
    end

    assign state_out = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
            cpu_ready  <= 1'b0;
            dma_ready  <= 1'b0;
            bus_err    <= 1'b0;
            grant      <= 2'b00;
`ifdef ARB_TIMEOUT_EN
            wd_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        mem_cs <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                        if (pick_dma) begin
                            state      <= DMA_ACC;
                            grant      <= 2'b10;
                            last_grant <= 1'b1;
                            mem_we     <= dma_we;
                            mem_addr   <= dma_addr;
                            mem_wdata  <= dma_wdata;
                        end else begin
                            state      <= CPU_ACC;
                            grant      <= 2'b01;
                            last_grant <= 1'b0;
                            mem_we     <= cpu_we;
                            mem_addr   <= cpu_addr;
                            mem_wdata  <= cpu_wdata;
                        end
                    end
                end

                // Requester inputs are ignored here; the latched request stays on the bus.
                CPU_ACC, DMA_ACC: begin
                    if (mem_ack) begin
                        mem_cs <= 1'b0;
                        state  <= RESP;
                        if (state == CPU_ACC) begin
                            cpu_ready <= 1'b1;
                            if (!mem_we) cpu_rdata <= mem_rdata;
                        end else begin
                            dma_ready <= 1'b1;
                            if (!mem_we) dma_rdata <= mem_rdata;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    // mem_ack is tested first so a same-cycle ack beats the watchdog.
                    else if (wd_cnt == WD_LAST) begin
                        mem_cs  <= 1'b0;
                        state   <= RESP;
                        bus_err <= 1'b1;
                        if (state == CPU_ACC) begin
                            cpu_ready <= 1'b1;
                            if (!mem_we) cpu_rdata <= DATA_W'(32'hDEADBEEF);
                        end else begin
                            dma_ready <= 1'b1;
                            if (!mem_we) dma_rdata <= DATA_W'(32'hDEADBEEF);
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
`endif
                end

                // The ready pulse is visible for this one cycle only.
                RESP: begin
                    cpu_ready <= 1'b0;
                    dma_ready <= 1'b0;
                    bus_err   <= 1'b0;
                    grant     <= 2'b00;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mio_arbiter.md
Name: mio_arbiter

Overview:
- Two-master arbiter for the shared memory/IO bus.
- Master 0 is the multicycle CPU's memory port (address, read/write strobes, data); master 1 is a DMA/VGA-style requester.
- Serialises accesses onto one memory slave, forwards its acknowledge back as a one-cycle ready pulse, and exposes its state for debug.
- The CPU controller's MIO_ready input is driven from cpu_ready.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- PRIO_CPU, 0, 0 = round-robin on simultaneous requests; 1 = CPU always wins a tie.
- TIMEOUT, 255, access watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, level, held until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  read data to CPU, valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse to CPU (MIO_ready).
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ready  same as the cpu_ prefixed ports, for master 1.
- mem_cs  out  1  slave select, held for the whole access.
- mem_we  out  1  slave write enable.
- mem_addr  out  ADDR_W  slave address.
- mem_wdata  out  DATA_W  slave write data.
- mem_rdata  in  DATA_W  slave read data, valid with mem_ack.
- mem_ack  in  1  slave completion; may assert any cycle after mem_cs rises, including the first.
- bus_err  out  1  access aborted by watchdog; pulses with ready.
- grant  out  2  one-hot current owner: bit0 = CPU, bit1 = DMA.
- state_out  out  2  current FSM state.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous): all outputs 0, state IDLE, last_grant=DMA so the CPU wins the first tie. Reset mid-access abandons the access immediately; mem_cs drops with no ready pulse.
- FSM states: IDLE=0, CPU_ACC=1, DMA_ACC=2, RESP=3.
- IDLE:
  - Only cpu_req → CPU_ACC.
  - Only dma_req → DMA_ACC.
  - Both, PRIO_CPU=1 → CPU_ACC.
  - Both, PRIO_CPU=0 → grant the master not equal to last_grant.
  - Neither → stay in IDLE.
  - On leaving IDLE: latch the winner's we/addr/wdata into mem_we/mem_addr/mem_wdata, set mem_cs=1, set grant, update last_grant.
- x_ACC:
  - Outputs held stable; requester inputs ignored.
  - On mem_ack: capture mem_rdata into the winner's rdata register, clear mem_cs, go to RESP. Next cycle, the winner's ready=1 for exactly one cycle.
- RESP: ready and grant clear, then → IDLE.
  - The master must drop req in the cycle it sees ready=1.
  - A req still high in IDLE is a new access.
- Latency: req sampled at edge k, mem_ack sampled at edge m (m ≥ k+1), ready high during cycle m..m+1. Minimum 3 cycles per access. Back-to-back CPU and DMA requests alternate.
- Read data:
  - rdata registers hold their value until the next read by the same master.
  - Writes leave rdata unchanged.
- Loser's req stays pending and is served in the next IDLE; nothing is dropped.
- Fixed priority (PRIO_CPU=1) may starve DMA. This is accepted behaviour.
- mem_ack outside x_ACC is ignored.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - An 8..16-bit counter clears on entry to x_ACC and increments each cycle without mem_ack.
  - At count==TIMEOUT: drop mem_cs, drive the winner's rdata=32'hDEADBEEF (reads only), pulse bus_err together with ready, go to RESP.
  - mem_ack in the same cycle as the timeout wins: normal completion, no bus_err.
- ARB_TIMEOUT_EN undefined:
  - Access waits for mem_ack indefinitely.
  - No counter is present; bus_err is tied 0.

Test Plan:
- CPU read 0x0000_0010, slave acks 2 cycles after mem_cs with 0x1234_5678 → mem_we=0, mem_addr=0x10, cpu_ready pulses 1 cycle with cpu_rdata=0x12345678; dma_ready stays 0.
- cpu_req and dma_req rise on the same edge after reset, PRIO_CPU=0, both held → CPU served first, then DMA, then CPU; grant sequence 01,00,10,00.
- PRIO_CPU=1, both continuously requesting → grant=01 every access; DMA never granted.
- DMA write 0xCAFE_0001 to 0x100, CPU requests mid-access → mem_addr/mem_wdata unchanged until mem_ack; CPU granted in the following IDLE.
- reset=0 pulse while in CPU_ACC with mem_ack pending → mem_cs, grant, cpu_ready are 0 immediately; state_out=0; no ready ever issued for that access.
- ARB_TIMEOUT_EN, TIMEOUT=8, slave never acks on a CPU read → after 8 cycles mem_cs=0, cpu_ready and bus_err pulse together, cpu_rdata=0xDEADBEEF.
